// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, and marks first/last blocks.
module sha1_pad (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_first,
    output logic         block_last
);

    typedef enum logic {FILL, EMIT} state_t;
    typedef enum logic [1:0] {TAIL_NONE, TAIL_ZERO, TAIL_PAD80} tail_t;

    state_t         state_q, state_d;
    tail_t          tail_q, tail_d;
    logic [511:0]   buf_q, buf_d;
    logic [5:0]     idx_q, idx_d;
    logic [63:0]    len_q, len_d;
    logic           first_q, first_d;
    logic           last_q, last_d;

    logic           accept;
    logic           wr_en;
    logic           pad_en;
    logic [6:0]     pos;
    logic [63:0]    len_add;
    logic [511:0]   fill_buf;

    assign accept  = in_valid & in_ready;
    assign wr_en   = accept & ~in_empty;
    assign pad_en  = accept & in_last;
    // Byte count in the block once this beat's byte (if any) is written.
    assign pos     = {1'b0, idx_q} + {6'b0, wr_en};
    assign len_add = len_q + {60'b0, wr_en, 3'b000};

    // Each byte lane takes the incoming byte, the 0x80 marker, or keeps its value.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_lane
            localparam logic [5:0] LANE_IDX = 6'(gi);
            localparam logic [6:0] LANE_POS = 7'(gi);
            assign fill_buf[511 - 8*gi -: 8] =
                (wr_en && (idx_q == LANE_IDX)) ? in_data :
                (pad_en && (pos == LANE_POS))  ? 8'h80   :
                                                 buf_q[511 - 8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        len_d   = len_q;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d = fill_buf;
                    len_d = len_add;
                    idx_d = idx_q + 6'(wr_en);
                    if (in_last) begin
                        state_d = EMIT;
                        if (pos <= 7'd55) begin
                            buf_d  = {fill_buf[511:64], len_add};
                            last_d = 1'b1;
                            tail_d = TAIL_NONE;
                        end else if (pos <= 7'd63) begin
                            last_d = 1'b0;
                            tail_d = TAIL_ZERO;
                        end else begin
                            last_d = 1'b0;
                            tail_d = TAIL_PAD80;
                        end
                    end else if (wr_en && (idx_q == 6'd63)) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                        tail_d  = TAIL_NONE;
                    end
                end
            end
            EMIT: begin
                if (block_ready) begin
                    if (tail_q == TAIL_ZERO) begin
                        buf_d   = {448'b0, len_q};
                        last_d  = 1'b1;
                        first_d = 1'b0;
                        tail_d  = TAIL_NONE;
                    end else if (tail_q == TAIL_PAD80) begin
                        buf_d   = {8'h80, 440'b0, len_q};
                        last_d  = 1'b1;
                        first_d = 1'b0;
                        tail_d  = TAIL_NONE;
                    end else begin
                        buf_d   = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        state_d = FILL;
                        if (last_q) begin
                            len_d   = '0;
                            first_d = 1'b1;
                        end else begin
                            first_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            tail_q  <= TAIL_NONE;
            buf_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign in_ready    = (state_q == FILL) & ~rst;
    assign block_valid = (state_q == EMIT);
    assign block_out   = buf_q;
    assign block_first = first_q;
    assign block_last  = last_q;

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: hand-computed padded blocks for short, boundary
// and multi-block messages, backpressure and reset behaviour.
module tb_sha1_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [7:0]   in_data;
    logic         in_last, in_empty;
    logic [511:0] block_out;
    logic         block_valid, block_ready, block_first, block_last;

    int vectors = 0;
    int errors  = 0;

    logic [511:0] s64;
    logic [447:0] s56;
    logic [439:0] s55;
    logic [511:0] held;

    sha1_pad dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
        .block_first(block_first), .block_last(block_last)
    );

    always #5 clk = ~clk;

    task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Bytes are taken from the left of msg; in_last goes with the n-th byte when last=1.
    task automatic send_bytes(input logic [519:0] msg, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = msg[519 - 8*i -: 8];
            in_last  = last && (i == n - 1);
            in_empty = 1'b0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) chk1("in_ready_timeout", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!block_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk1(tag, block_valid, 1'b1);
    endtask

    task automatic handshake();
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
    endtask

    task automatic expect_block(input string tag, input logic [511:0] exp,
                                input logic first, input logic last);
        wait_valid({tag, "_valid"});
        chk512({tag, "_data"}, block_out, exp);
        chk1({tag, "_first"}, block_first, first);
        chk1({tag, "_last"}, block_last, last);
    endtask

    initial begin
        s64 = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789+/";
        s56 = s64[511:64];
        s55 = s64[511:72];
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_empty = 1'b0; block_ready = 1'b0;

        // Reset state
        #12;
        chk1("rst_in_ready", in_ready, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_valid", block_valid, 1'b0);
        chk512("reset_block", block_out, 512'b0);
        chk1("reset_first", block_first, 1'b1);
        chk1("reset_last", block_last, 1'b0);

        // "abc": single block, valid one cycle after the last beat
        send_bytes({24'h616263, 496'b0}, 3, 1'b1);
        chk1("abc_latency", block_valid, 1'b1);
        expect_block("abc", {32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
        handshake();
        chk1("abc_in_ready_back", in_ready, 1'b1);
        chk1("abc_valid_drop", block_valid, 1'b0);

        // Zero-length message
        send_beat(8'h00, 1'b1, 1'b1);
        expect_block("empty", {8'h80, 440'b0, 64'h0}, 1'b1, 1'b1);
        handshake();

        // Illegal empty non-last beat is ignored
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'hEE, 1'b0, 1'b1);
        send_beat(8'h63, 1'b1, 1'b0);
        expect_block("illegal_empty", {32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);
        handshake();

        // 55 bytes: fits with length
        send_bytes({s55, 80'b0}, 55, 1'b1);
        expect_block("len55", {s55, 8'h80, 64'h1B8}, 1'b1, 1'b1);
        handshake();

        // 56 bytes: 0x80 block then zero+length block, back to back
        send_bytes({s56, 72'b0}, 56, 1'b1);
        expect_block("len56_a", {s56, 8'h80, 56'h0}, 1'b1, 1'b0);
        handshake();
        chk1("len56_b_backtoback", block_valid, 1'b1);
        chk1("len56_b_in_ready", in_ready, 1'b0);
        expect_block("len56_b", {448'b0, 64'h1C0}, 1'b0, 1'b1);
        handshake();

        // 64 bytes: data block then 0x80 + length block
        send_bytes({s64, 8'b0}, 64, 1'b1);
        expect_block("len64_a", s64, 1'b1, 1'b0);
        handshake();
        chk1("len64_b_backtoback", block_valid, 1'b1);
        expect_block("len64_b", {8'h80, 440'b0, 64'h200}, 1'b0, 1'b1);
        handshake();

        // 65 bytes: full block, refill, then byte64 + 0x80 + length
        send_bytes({s64, 8'b0}, 64, 1'b0);
        chk1("len65_latency", block_valid, 1'b1);
        expect_block("len65_a", s64, 1'b1, 1'b0);
        handshake();
        chk1("len65_refill_ready", in_ready, 1'b1);
        send_bytes({8'h5A, 512'b0}, 1, 1'b1);
        expect_block("len65_b", {8'h5A, 8'h80, 432'b0, 64'h208}, 1'b0, 1'b1);
        handshake();
        chk1("len65_first_rearmed", block_first, 1'b1);

        // Backpressure: outputs hold while block_ready stays low
        send_bytes({24'h616263, 496'b0}, 3, 1'b1);
        wait_valid("bp_valid");
        held = block_out;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk512("bp_hold_data", block_out, {32'h61626380, 416'b0, 64'h18});
            chk1("bp_hold_valid", block_valid, 1'b1);
            chk1("bp_hold_first", block_first, 1'b1);
            chk1("bp_hold_last", block_last, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        handshake();
        chk1("bp_released", in_ready, 1'b1);

        // Reset mid-message, then "abc" must be unaffected
        send_bytes({s64, 8'b0}, 30, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk512("midrst_cleared", block_out, 512'b0);
        send_bytes({24'h616263, 496'b0}, 3, 1'b1);
        expect_block("midrst_abc", {32'h61626380, 416'b0, 64'h18}, 1'b1, 1'b1);

        // Reset while a block is presented drops block_valid asynchronously
        #2 rst = 1'b1;
        #1;
        chk1("emit_rst_valid", block_valid, 1'b0);
        chk512("emit_rst_data", block_out, 512'b0);
        chk1("emit_rst_first", block_first, 1'b1);
        chk1("emit_rst_last", block_last, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
